iter_div: RTL and testbench
===========================

ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-005 SHALL have port in_valid  input  1  request offered.
REQ-006 SHALL have port in_ready  output  1  divider can accept a request.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled at acceptance.
REQ-008 SHALL have ports dividend, divisor  input  WIDTH  operands, sampled at acceptance.
REQ-009 SHALL have port out_valid  output  1  result held for consumer.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have ports quotient, remainder  output  WIDTH  registered results.
REQ-012 SHALL have port div_by_zero  output  1  result came from zero divisor; qualified by out_valid.

Function
REQ-013 SHALL implement FSM IDLE, CALC, DONE; in_ready = (state == IDLE).
REQ-014 Acceptance SHALL occur on edge where in_valid & in_ready & !flush; operands, is_signed captured, magnitudes formed.
REQ-015 IDLE -> CALC on acceptance; CALC runs exactly WIDTH restoring radix-2 iterations, one per cycle, iteration counter 0..WIDTH-1.
REQ-016 CALC -> DONE after iteration WIDTH-1; out_valid high from edge k+WIDTH+1 where k is acceptance edge.
REQ-017 Sign fix-up SHALL be applied when entering DONE: quotient negated iff signed and operand signs differ; remainder takes dividend's sign.
REQ-018 DONE: outputs and out_valid held stable until out_valid & out_ready; then -> IDLE next edge; no new acceptance in that same cycle.
REQ-019 Divisor zero SHALL skip CALC: IDLE -> DONE at k+1, quotient all-ones, remainder = dividend, div_by_zero = 1.
REQ-020 Signed MIN / -1 SHALL yield quotient = MIN, remainder = 0, div_by_zero = 0, no trap.
REQ-021 Unsigned mode SHALL treat all WIDTH bits as magnitude; internal partial remainder WIDTH+1 bits.
REQ-022 flush SHALL force IDLE on next edge from any state, drop out_valid, leave quotient/remainder unchanged; flush has priority over acceptance and out_ready.
REQ-023 Operand inputs SHALL be ignored outside the acceptance edge.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, counter 0, out_valid 0, div_by_zero 0, quotient 0, remainder 0.
REQ-025 Reset mid-CALC SHALL discard the operation with no output produced after release.
REQ-026 First acceptance SHALL be possible on first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro ITER_DIV_EARLY_EXIT_EN defined: if |dividend| < |divisor| (nonzero divisor) at acceptance, IDLE -> DONE at k+1 with quotient 0, remainder = dividend.
REQ-028 Macro undefined: such operands take full WIDTH+1 latency with identical results.

Structure
REQ-029 Package div_pkg SHALL hold the state enum type and DIV_WIDTH_DEFAULT constant.
REQ-030 Sub-module div_negate (conditional two's-complement negate, WIDTH param) SHALL be used for operand magnitude and result fix-up.

Verification
REQ-031 Unsigned 100/7, WIDTH=32 -> quotient 14, remainder 2, out_valid at k+33.
REQ-032 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-033 Divisor 0, dividend 0x12345678 -> out_valid at k+1, quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; out_ready held low 5 cycles -> outputs stable, in_ready 0.
REQ-035 flush at iteration 10 -> IDLE next edge, out_valid never asserted; next request 9/3 -> quotient 3, remainder 0.
REQ-036 With ITER_DIV_EARLY_EXIT_EN, 3/10 -> out_valid at k+1, quotient 0, remainder 3; without, at k+33 same values.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_negate.sv
// Conditional two's-complement negate; combinational, no backpressure.
module div_negate
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/iter_div.sv
// Restoring radix-2 signed/unsigned divider; ITER_DIV_EARLY_EXIT_EN adds a |dividend|<|divisor| fast path.
// Latency WIDTH+1 cycles (1 for zero divisor); result held until out_ready, in_ready only while idle.
module iter_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_skip;
    logic             r_fix;
    logic             r_zero;
    logic             r_dbz;

    logic             w_accept;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic             w_dvs_zero;
    logic             w_early;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
    assign w_dvs_zero = (divisor == '0);

    div_negate #(.WIDTH(WIDTH)) u_neg_dvd (.i_neg(w_dvd_neg), .i_val(dividend), .o_val(w_dvd_mag));
    div_negate #(.WIDTH(WIDTH)) u_neg_dvs (.i_neg(w_dvs_neg), .i_val(divisor),  .o_val(w_dvs_mag));
    div_negate #(.WIDTH(WIDTH)) u_fix_q   (.i_neg(r_neg_q),   .i_val(r_quo),    .o_val(w_q_fix));
    div_negate #(.WIDTH(WIDTH)) u_fix_r   (.i_neg(r_neg_r),   .i_val(r_rem),    .o_val(w_r_fix));

`ifdef ITER_DIV_EARLY_EXIT_EN
    assign w_early = ~w_dvs_zero & (w_dvd_mag < w_dvs_mag);
`else
    assign w_early = 1'b0;
`endif

    // WIDTH+1-bit partial remainder; the difference always fits WIDTH bits when it is kept.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvsr});
    assign w_diff  = w_shift[WIDTH-1:0] - r_dvsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_skip      <= 1'b0;
            r_fix       <= 1'b0;
            r_zero      <= 1'b0;
            r_dbz       <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_skip  <= 1'b0;
            r_fix   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_CALC;
                        r_cnt   <= '0;
                        r_fix   <= 1'b0;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_dvsr  <= w_dvs_mag;
                        r_zero  <= w_dvs_zero;
                        // Fast paths return the raw dividend as remainder, so park it in r_rem.
                        if (w_dvs_zero || w_early) begin
                            r_skip <= 1'b1;
                            r_rem  <= dividend;
                            r_quo  <= '0;
                        end else begin
                            r_skip <= 1'b0;
                            r_rem  <= '0;
                            r_quo  <= w_dvd_mag;
                        end
                    end
                end
                S_CALC: begin
                    if (r_skip) begin
                        r_state     <= S_DONE;
                        r_skip      <= 1'b0;
                        r_quotient  <= {WIDTH{r_zero}};
                        r_remainder <= r_rem;
                        r_dbz       <= r_zero;
                    end else if (r_fix) begin
                        r_state     <= S_DONE;
                        r_fix       <= 1'b0;
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                        r_dbz       <= 1'b0;
                    end else begin
                        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                        if (r_cnt == CNT_LAST) begin
                            r_cnt <= '0;
                            r_fix <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Scoreboard bench for iter_div at WIDTH=32: stimulus pushes expectations, negedge monitor checks.
module tb_iter_div;

    localparam int W = 32;
`ifdef ITER_DIV_EARLY_EXIT_EN
    localparam int EE_LAT = 1;
`else
    localparam int EE_LAT = 33;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           k;
        int           lat;
        string        nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    bit   prev_ov = 1'b0;

    iter_div #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", nm, act_v, exp_v);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, data on the handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0)
                    check("unexpected_output", 64'(out_valid), 64'd0);
                else
                    check({exp_q[0].nm, "_latency"}, 64'(cyc - exp_q[0].k), 64'(exp_q[0].lat));
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check({cur.nm, "_quotient"},  64'(quotient),    64'(cur.q));
                check({cur.nm, "_remainder"}, 64'(remainder),   64'(cur.r));
                check({cur.nm, "_dbz"},       64'(div_by_zero), 64'(cur.dbz));
            end
        end
        prev_ov = out_valid;
    end

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input int lat, input string nm);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({nm, "_in_ready_wait"}, 64'(in_ready), 64'd1);
            return;
        end
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.dbz = edbz;
            e.k   = cyc + 1;
            e.lat = lat;
            e.nm  = nm;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        is_signed = ~sgn;
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int saw;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_quotient",  64'(quotient),    64'd0);
        check("rst_remainder", 64'(remainder),   64'd0);
        check("rst_dbz",       64'(div_by_zero), 64'd0);
        rst_n = 1'b1;

        // Accepted on the first edge after reset release.
        issue(1'b0, 32'd100,        32'd7,          1'b1, 32'd14,         32'd2,          1'b0, 33, "u100_7");
        issue(1'b1, 32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33, "s_m7_2");
        issue(1'b1, 32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 33, "s_7_m2");
        issue(1'b0, 32'h12345678,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h12345678,   1'b1, 1,  "div0");
        issue(1'b1, 32'hFFFFFF00,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFF00,   1'b1, 1,  "div0_neg");
        issue(1'b0, 32'hFFFFFFFF,   32'd1,          1'b1, 32'hFFFFFFFF,   32'd0,          1'b0, 33, "u_max_1");
        issue(1'b0, 32'h80000000,   32'd3,          1'b1, 32'h2AAAAAAA,   32'd2,          1'b0, 33, "u_8000_3");
        issue(1'b0, 32'hFFFFFFF9,   32'd2,          1'b1, 32'h7FFFFFFC,   32'd1,          1'b0, 33, "u_fff9_2");
        issue(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0, 33, "s_m100_m7");
        issue(1'b0, 32'd3,          32'd10,         1'b1, 32'd0,          32'd3,          1'b0, EE_LAT, "u3_10");
        issue(1'b1, 32'd5,          32'hFFFFFFF7,   1'b1, 32'd0,          32'd5,          1'b0, EE_LAT, "s_5_m9");
        issue(1'b1, 32'hFFFFFFFD,   32'd7,          1'b1, 32'd0,          32'hFFFFFFFD,   1'b0, EE_LAT, "s_m3_7");
        drain();

        // MIN / -1 with the consumer stalled.
        out_ready = 1'b0;
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 33, "min_m1");
        saw = 0;
        while (!out_valid && saw < 100) begin
            @(negedge clk);
            saw++;
        end
        check("min_m1_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_quotient",  64'(quotient),  64'h80000000);
            check("hold_remainder", 64'(remainder), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready",  64'(in_ready),  64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // Flush sampled on the edge of iteration 10.
        issue(1'b0, 32'd1000, 32'd3, 1'b0, '0, '0, 1'b0, 0, "flush_op");
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready",  64'(in_ready),  64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_quotient",  64'(quotient),  64'h80000000);
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw++;
        end
        check("flush_no_output", 64'(saw), 64'd0);
        issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 33, "u9_3_after_flush");
        drain();

        // Asynchronous reset in the middle of an operation.
        issue(1'b0, 32'd50, 32'd5, 1'b0, '0, '0, 1'b0, 0, "rst_op");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready",  64'(in_ready),    64'd1);
        check("arst_out_valid", 64'(out_valid),   64'd0);
        check("arst_quotient",  64'(quotient),    64'd0);
        check("arst_remainder", 64'(remainder),   64'd0);
        check("arst_dbz",       64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw++;
        end
        check("arst_no_output", 64'(saw), 64'd0);
        issue(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, "s_m100_7");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
